// File: rtl/lab3_defs.sv
// lab3_defs: shared definitions for the FIFO-to-UART drain path.
// Holds the drain FSM state encoding and the default clock and baud rates.
package lab3_defs;

  localparam int DEF_CLK_FREQ = 16_000_000;
  localparam int DEF_BAUD     = 115200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: counts clocks within one UART bit period.
// clk, rst_n (async, active low), clear_i restarts the count, bit_end_o on the last cycle of a bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 138
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a standard-mode FIFO and sends them as UART 8N1, LSB first.
// Ports: clk, rst_n, enable, fifo_empty, fifo_dout in; fifo_rd_en, tx, busy, byte_done out.
module fifo_uart_tx
  import lab3_defs::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [BW-1:0]     bit_q;
  logic [BW-1:0]     bit_d;
  logic              tx_q;
  logic              tx_d;
  logic              bit_end;
  logic              last_bit;
  logic              cnt_clr;

  // Restarting the count on every state change aligns bit
  // boundaries to START entry.
  assign cnt_clr = (state_d != state_q);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (cnt_clr),
    .bit_end_o(bit_end)
  );

  assign last_bit = (bit_q == BW'(DATA_W - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable && !fifo_empty) state_d = ST_POP;
      ST_POP:   state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA:  if (bit_end && last_bit) state_d = ST_STOP;
      ST_STOP:  if (bit_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    if (state_q == ST_LOAD) begin
      shift_d = fifo_dout;
    end
    if (state_q == ST_DATA && bit_end) begin
      shift_d = shift_q >> 1;
      bit_d   = last_bit ? '0 : bit_q + BW'(1);
    end
  end

  // tx is computed from next state so the registered line
  // lines up with state_q and never glitches.
  always_comb begin
    tx_d = 1'b1;
    unique case (1'b1)
      (state_d == ST_START): tx_d = 1'b0;
      (state_d == ST_DATA):  tx_d = shift_d[0];
      default:               tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = (state_q == ST_POP);
  assign busy       = (state_q != ST_IDLE);
  assign byte_done  = (state_q == ST_STOP) && bit_end;

endmodule
